sm_hex_display: RTL and testbench

//  Consumer end of the sm_top debug readout (regData / dmRDataOut): scans a 32-bit word onto a

---
 rtl/sm_hex_display_pkg.sv | 26 ++
 rtl/sm_hex_display_if.sv | 31 +++
 rtl/sm_hex_to_seg.sv | 12 +
 rtl/sm_hex_display.sv | 178 +++++++++++++++++
 tb/tb_sm_hex_display.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/sm_hex_display_pkg.sv
// Shared definitions for the hex 7-segment scanner: segment width,
// nibble/segment types, the blank pattern and the 16-entry glyph table.
// Glyphs are stored active-high in {g,f,e,d,c,b,a} order; the top
// applies the board polarity.
package sm_hex_display_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;
  typedef logic [3:0]       nibble_t;

  // Active-high "no segment lit" pattern
  localparam seg_t SEG_BLANK = 7'h00;

  // Entry i lives at bits [i*SEG_W +: SEG_W]; listed from F down to 0
  localparam logic [16*SEG_W-1:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Look up the active-high glyph for one hex nibble
  function automatic seg_t glyph_of(input nibble_t nib);
    return GLYPH_TABLE[nib*SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/sm_hex_display_if.sv
// Display-side bundle of the hex scanner: enable/data going in,
// anode/segment drive and the frame marker coming out.
// master = producer of the word (e.g. debug readout), slave = scanner.
interface sm_hex_display_if #(
  parameter int DIGITS = 8
);
  import sm_hex_display_pkg::*;

  logic                  enable;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     anodes;
  seg_t                  segments;
  logic                  frameStart;

  modport master (
    output enable,
    output data,
    input  anodes,
    input  segments,
    input  frameStart
  );

  modport slave (
    input  enable,
    input  data,
    output anodes,
    output segments,
    output frameStart
  );

endinterface

// File: rtl/sm_hex_to_seg.sv
// Combinational hex nibble to active-high 7-segment glyph ({g,f,e,d,c,b,a}).
// Polarity for the physical display is applied by the caller.
module sm_hex_to_seg
  import sm_hex_display_pkg::*;
(
  input  nibble_t nibble_i,
  output seg_t    glyph_o
);

  assign glyph_o = glyph_of(nibble_i);

endmodule

// File: rtl/sm_hex_display.sv
// Multiplexed hex 7-segment scanner for a 4*DIGITS-bit debug word.
// The word is latched into a shadow register once per frame so a digit
// sweep never mixes two words; each digit slot starts with a short
// blanking interval (all anodes off) to avoid ghosting between digits.
// Optional feature: define SM_HEX_DISPLAY_LZB_EN for leading-zero blanking
// (digits above the most significant nonzero nibble stay dark; digit 0
// is always shown).
module sm_hex_display
  import sm_hex_display_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int REFRESH_SHIFT = 10,
  parameter int BLANK_CYCLES  = 4,
  parameter int ANODE_ACT_LOW = 1,
  parameter int SEG_ACT_LOW   = 1
) (
  input logic             clk,
  input logic             rst,
  sm_hex_display_if.slave dsp
);

  localparam int DATA_W = 4 * DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [REFRESH_SHIFT-1:0] CNT_ONE   = REFRESH_SHIFT'(1);
  localparam logic [REFRESH_SHIFT-1:0] BLANK_END = REFRESH_SHIFT'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]         IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]         IDX_LAST  = IDX_W'(DIGITS - 1);

  // Inactive drive levels after polarity is applied
  localparam logic [DIGITS-1:0] ANODE_OFF =
    (ANODE_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam seg_t SEG_OFF = (SEG_ACT_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

  // Scan state
  logic [REFRESH_SHIFT-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATA_W-1:0]        shadow_q, shadow_d;

  // Output registers
  logic [DIGITS-1:0]        anodes_q, anodes_d;
  seg_t                     segments_q, segments_d;
  logic                     frame_start_q, frame_start_d;

  // Decode helpers
  nibble_t                  shadow_nib [DIGITS];
  logic [DIGITS-1:0]        anode_hot;
  nibble_t                  cur_nibble;
  seg_t                     cur_glyph;
  seg_t                     seg_lit;
  logic [DIGITS-1:0]        anode_on;
  logic                     capture;
  logic                     slot_blank;
  logic                     digit_hidden;

  // Split the shadow word into nibbles and build the one-hot digit select
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign shadow_nib[gi] = shadow_q[4*gi +: 4];
      assign anode_hot[gi]  = (idx_q == IDX_W'(gi));
    end
  endgenerate

  assign cur_nibble = shadow_nib[idx_q];

  sm_hex_to_seg u_hex_to_seg (
    .nibble_i (cur_nibble),
    .glyph_o  (cur_glyph)
  );

  assign seg_lit  = (SEG_ACT_LOW   != 0) ? ~cur_glyph : cur_glyph;
  assign anode_on = (ANODE_ACT_LOW != 0) ? ~anode_hot : anode_hot;

  // A new word is taken at the very start of digit 0's slot, which is
  // always inside the blanking window, so no half-updated digit is shown.
  assign capture    = dsp.enable && (cnt_q == '0) && (idx_q == '0);
  assign slot_blank = (cnt_q < BLANK_END);

`ifdef SM_HEX_DISPLAY_LZB_EN
  logic [IDX_W-1:0] msd_q, msd_d;
  logic [IDX_W-1:0] data_msd;
  nibble_t          data_nib [DIGITS];

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_data_nib
      assign data_nib[gi] = dsp.data[4*gi +: 4];
    end
  endgenerate

  // Index of the highest nonzero nibble of the incoming word (0 if all zero)
  always_comb begin
    data_msd = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (data_nib[i] != 4'h0) begin
        data_msd = IDX_W'(i);
      end
    end
  end

  // Digits above the most significant nonzero one stay dark for the slot
  assign digit_hidden = (idx_q > msd_q);

  // Latch the leading-digit index together with the shadow word
  always_comb begin
    msd_d = msd_q;
    if (capture) begin
      msd_d = data_msd;
    end
  end

  // Leading-digit register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msd_q <= '0;
    end else begin
      msd_q <= msd_d;
    end
  end
`else
  assign digit_hidden = 1'b0;
`endif

  // Next-state: advance the scan only while enabled; otherwise everything
  // holds and the frame marker stays low.
  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    anodes_d      = anodes_q;
    segments_d    = segments_q;
    frame_start_d = 1'b0;

    if (dsp.enable) begin
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_q == '1) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
      end

      if (capture) begin
        shadow_d      = dsp.data;
        frame_start_d = 1'b1;
      end

      if (slot_blank || digit_hidden) begin
        anodes_d   = ANODE_OFF;
        segments_d = SEG_OFF;
      end else begin
        anodes_d   = anode_on;
        segments_d = seg_lit;
      end
    end
  end

  // Scan and output registers; reset forces the display dark immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      anodes_q      <= ANODE_OFF;
      segments_q    <= SEG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      anodes_q      <= anodes_d;
      segments_q    <= segments_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign dsp.anodes     = anodes_q;
  assign dsp.segments   = segments_q;
  assign dsp.frameStart = frame_start_q;

endmodule

// File: tb/tb_sm_hex_display.sv
// Directed bench for sm_hex_display (DIGITS=8, REFRESH_SHIFT=4,
// BLANK_CYCLES=2, active-low anodes and segments). Honours
// SM_HEX_DISPLAY_LZB_EN when choosing expected values.
module tb_sm_hex_display;
  import sm_hex_display_pkg::*;

  localparam int DIGITS = 8;
  localparam int SLOT   = 16;
  localparam int FRAME  = 128;
  localparam int BLANK  = 2;
`ifdef SM_HEX_DISPLAY_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  sm_hex_display_if #(.DIGITS(DIGITS)) dsp_if ();

  sm_hex_display #(
    .DIGITS        (DIGITS),
    .REFRESH_SHIFT (4),
    .BLANK_CYCLES  (BLANK),
    .ANODE_ACT_LOW (1),
    .SEG_ACT_LOW   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dsp (dsp_if)
  );

  always #5 clk = ~clk;

  // Hand-derived active-low glyphs, digits 0..F
  logic [6:0] seg_lo [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int         checks    = 0;
  int         failures  = 0;
  int         n;          // enabled edges since the run started
  int         blank_run;
  bit         track_blank;
  logic [31:0] m_shadow;
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_fs;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic int msd_of(input logic [31:0] w);
    int m = 0;
    for (int i = 1; i < 8; i++) begin
      if (w[4*i +: 4] != 4'h0) m = i;
    end
    return m;
  endfunction

  // Release reset at a falling edge and start a fresh expected sequence
  task automatic start_run(input logic [31:0] word);
    rst         = 1'b0;
    dsp_if.data = word;
    n           = 0;
    m_shadow    = 32'h0;
    exp_an      = 8'hFF;
    exp_seg     = 7'h7F;
    blank_run   = 0;
  endtask

  // One clock edge with the given enable; checks outputs at the falling edge
  task automatic tick(input bit en);
    int cnt;
    int slot;
    dsp_if.enable = en;
    @(posedge clk);
    @(negedge clk);
    if (en) begin
      cnt    = n % SLOT;
      slot   = (n / SLOT) % DIGITS;
      exp_fs = (n % FRAME == 0);
      if (exp_fs) m_shadow = dsp_if.data;
      if (cnt < BLANK || (LZB && slot > msd_of(m_shadow))) begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
      end else begin
        exp_an  = ~(8'b1 << slot);
        exp_seg = seg_lo[m_shadow[4*slot +: 4]];
      end
      n++;
    end else begin
      exp_fs = 1'b0;
    end
    check_val($sformatf("anodes n=%0d", n), {24'h0, dsp_if.anodes}, {24'h0, exp_an});
    check_val($sformatf("segments n=%0d", n), {25'h0, dsp_if.segments}, {25'h0, exp_seg});
    check_val($sformatf("frameStart n=%0d", n), {31'h0, dsp_if.frameStart}, {31'h0, exp_fs});
    if (track_blank) begin
      if (dsp_if.anodes == 8'hFF) begin
        blank_run++;
      end else begin
        if (blank_run > 0) check_val($sformatf("blank_run n=%0d", n), blank_run, 2);
        blank_run = 0;
      end
    end
    $display("edge en=%0d n=%0d anodes=%h segments=%h frameStart=%0d",
             en, n, dsp_if.anodes, dsp_if.segments, dsp_if.frameStart);
  endtask

  initial begin
    int tot;
    int fs_edge;
    bit seen;

    dsp_if.enable = 1'b0;
    dsp_if.data   = 32'h0;
    track_blank   = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset anodes", {24'h0, dsp_if.anodes}, 32'hFF);
    check_val("reset segments", {25'h0, dsp_if.segments}, 32'h7F);
    check_val("reset frameStart", {31'h0, dsp_if.frameStart}, 32'h0);

    // Free-running scan, tearing check and blanking-run check
    start_run(32'h76543210);
    track_blank = 1'b1;
    for (int e = 0; e < 144; e++) begin
      if (e == 50) dsp_if.data = 32'hFFFFFFFF;
      tick(1'b1);
      case (e)
        0:   check_val("first frameStart", {31'h0, dsp_if.frameStart}, 32'h1);
        1:   check_val("frameStart one cycle", {31'h0, dsp_if.frameStart}, 32'h0);
        17:  check_val("slot1 blank", {24'h0, dsp_if.anodes}, 32'hFF);
        21:  check_val("digit1 glyph", {25'h0, dsp_if.segments}, 32'h79);
        60:  check_val("digit3 old word", {25'h0, dsp_if.segments}, 32'h30);
        127: check_val("digit7 old word", {25'h0, dsp_if.segments}, 32'h78);
        128: check_val("second frameStart", {31'h0, dsp_if.frameStart}, 32'h1);
        130: check_val("digit0 new word", {25'h0, dsp_if.segments}, 32'h0E);
        143: check_val("digit0 anode", {24'h0, dsp_if.anodes}, 32'hFE);
        default: ;
      endcase
    end
    track_blank = 1'b0;

    // Asynchronous reset mid-slot takes effect without a clock edge
    #2 rst = 1'b1;
    #1;
    check_val("async rst anodes", {24'h0, dsp_if.anodes}, 32'hFF);
    check_val("async rst segments", {25'h0, dsp_if.segments}, 32'h7F);
    check_val("async rst frameStart", {31'h0, dsp_if.frameStart}, 32'h0);
    @(negedge clk);

    // Enable hold for 20 cycles starting at cycle 37
    start_run(32'h76543210);
    for (int e = 0; e < 37; e++) tick(1'b1);
    for (int e = 0; e < 20; e++) tick(1'b0);
    check_val("hold anodes", {24'h0, dsp_if.anodes}, 32'hFB);
    check_val("hold segments", {25'h0, dsp_if.segments}, 32'h24);
    tot     = 57;
    fs_edge = -1;
    seen    = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      tick(1'b1);
      tot++;
      if (dsp_if.frameStart) begin
        seen    = 1'b1;
        fs_edge = tot - 1;
      end
    end
    check_val("delayed frameStart edge", fs_edge, 148);

    // Leading-digit behaviour with a sparse word, then an all-zero word
    #2 rst = 1'b1;
    @(negedge clk);
    start_run(32'h000000A1);
    for (int e = 0; e < 160; e++) begin
      if (e == 100) dsp_if.data = 32'h0;
      tick(1'b1);
      case (e)
        2:   check_val("A1 digit0", {25'h0, dsp_if.segments}, 32'h79);
        18:  check_val("A1 digit1", {25'h0, dsp_if.segments}, 32'h08);
        34:  check_val("A1 digit2 anodes", {24'h0, dsp_if.anodes}, LZB ? 32'hFF : 32'hFB);
        120: check_val("A1 digit7 segments", {25'h0, dsp_if.segments}, LZB ? 32'h7F : 32'h40);
        130: check_val("zero digit0", {25'h0, dsp_if.segments}, 32'h40);
        146: check_val("zero digit1 anodes", {24'h0, dsp_if.anodes}, LZB ? 32'hFF : 32'hFD);
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
